idc_param: RTL
==============

Name: idc_param

Overview:
- Parametrised image display controller. It accepts a square IMG x IMG signed image and a list of NOPS window opcodes.
- Opcodes are applied one per cycle to a movable 2x2 window. The block then streams out an (IMG/2)x(IMG/2) zoom-in or shrink view.
- It sits between the pixel-stream front end and the display output stage.
- Generalises the fixed 8x8 / 7-bit / 15-op controller: configurable geometry and width, saturating flip, NOP opcodes, gap-tolerant input and deterministic execute latency.

Parameters:
- DW, 7, pixel width (signed two's complement), 4..12
- IMG, 8, image side length, power of two, 4..16
- NOPS, 15, opcodes per frame, 1..IMG*IMG

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  pixel/op stream valid
- in_data  in  DW  signed pixel, raster order (row-major, index = row*IMG+col)
- op  in  4  opcode, sampled on the first NOPS accepted beats
- busy  out  1  high in EXEC and OUTPUT
- out_valid  out  1  output beat valid
- out_data  out  DW  signed output pixel; 0 when out_valid low

Behaviour:
- Reset: rst_n sampled low at a clk edge clears state to IDLE, all counters, image and op registers, busy, out_valid and out_data (all 0). Reset mid-frame aborts the frame with no residual output.
- State machine: IDLE -> LOAD -> EXEC -> OUTPUT -> IDLE.
  - IDLE: first in_valid beat is accepted as pixel 0; go to LOAD.
  - LOAD: each in_valid-high cycle stores one pixel and increments the beat counter. in_valid low holds the counter (gaps allowed).
  - LOAD exit: after beat IMG*IMG-1 is accepted at cycle T, go to EXEC.
  - EXEC: cycles T+1..T+NOPS execute op[0..NOPS-1] in order, one per cycle. Image and window updates are visible to the next op.
  - OUTPUT: cycles T+NOPS+1 .. T+NOPS+(IMG/2)^2, out_valid high for exactly (IMG/2)^2 consecutive cycles. Then IDLE.
  - in_valid during EXEC/OUTPUT is ignored. A new frame may start the cycle after the last out_valid.
- Window:
  - Top-left (r,c) resets to (IMG/2-1, IMG/2-1) at each frame start.
  - Covers A=(r,c), B=(r,c+1), C=(r+1,c), D=(r+1,c+1).
  - Legal range is r,c in 0..IMG-2. A move that would leave the range is ignored; the cycle is still consumed.
- Opcodes:
  - 0 Midpoint: all four := (min(max(A,B),max(C,D)) + max(min(A,B),min(C,D))) / 2. Sum in DW+1 bits, truncate toward zero.
  - 1 Average: all four := (A+B+C+D)/4. Sum in DW+2 bits, truncate toward zero.
  - 2 CCW: A:=B, B:=D, C:=A, D:=C.
  - 3 CW: A:=C, B:=A, C:=D, D:=B.
  - 4 Flip: each := -x, saturating; -2^(DW-1) maps to 2^(DW-1)-1.
  - 5 Up (r-1), 6 Left (c-1), 7 Down (r+1), 8 Right (c+1).
  - 9..15: NOP.
- Output selection, using the final (r,c):
  - Zoom: if r<IMG/2 and c<IMG/2, output rows r+1..r+IMG/2 x cols c+1..c+IMG/2, raster order.
  - Shrink: otherwise output even rows x even cols: (0,0),(0,2)...(IMG-2,IMG-2), raster order.
- Simultaneous events: reset dominates everything. in_valid at an IDLE/LOAD boundary never loses or duplicates a beat.

Test Plan:
- Pass-through (IMG=8, DW=7):
  - Stimulus: pixel[i]=i-32, all ops=9.
  - Required: first out_valid 16 cycles after the last in_valid, 16 beats, zoom from (4,4). Data 4,5,6,7,12,...,31; busy high through OUTPUT.
- Move to shrink:
  - Stimulus: same image, op[0]=8 (Right), rest NOP.
  - Required: window (3,4) gives shrink output -32,-30,-28,-26,-16,...,22.
- Midpoint and average:
  - Pixels 27,28,35,36 = 10,-5,7,3, others 0, op[0]=0: out_data[0]=5.
  - Same pixels = -3,-2,-1,-1, op[0]=1: out_data[0]=-1 (truncation toward zero).
- Saturation and clamping:
  - Pixel 36=-64, op[0]=4: out_data[0]=63.
  - Ops 5,5,5,5,5,6,6,6,6,6 (rest NOP): window clamps at (0,0); out_data[0]=pixel[9].
- Rotation round-trip:
  - Pixels 27,28,35,36 = 1,2,3,4, ops 2,3: unchanged.
  - Ops 3 alone: pixel 36 becomes 2, so out_data[0]=2.
- Gaps and reset:
  - in_valid low for 5 cycles mid-LOAD: identical output, shifted by 5 cycles.
  - rst_n low one cycle during the 3rd output beat: out_valid=0, out_data=0 from that edge; busy=0.
  - A fresh frame then completes correctly.

Source files
------------

// File: rtl/idc_param.sv
// Image display controller: loads an IMG x IMG signed image plus NOPS window opcodes,
// applies them to a movable 2x2 window, then streams an (IMG/2)^2 zoom or shrink view.
module idc_param #(
    parameter int DW   = 7,
    parameter int IMG  = 8,
    parameter int NOPS = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    input  logic [3:0]           op,
    output logic                 busy,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data
);
    localparam int LW   = $clog2(IMG);
    localparam int CW   = 2 * LW;
    localparam int HW   = LW - 1;
    localparam int NPIX = IMG * IMG;
    localparam int HALF = IMG / 2;

    localparam logic [CW-1:0] LAST_PIX  = CW'(NPIX - 1);
    localparam logic [CW-1:0] LAST_OP   = CW'(NOPS - 1);
    localparam logic [CW-1:0] LAST_OUT  = CW'(HALF * HALF - 1);
    localparam logic [CW:0]   NOPS_W    = (CW + 1)'(NOPS);
    localparam logic [LW-1:0] WIN_START = LW'(HALF - 1);
    localparam logic [LW-1:0] WIN_MAX   = LW'(IMG - 2);

    localparam logic [3:0] OP_MID   = 4'd0;
    localparam logic [3:0] OP_AVG   = 4'd1;
    localparam logic [3:0] OP_CCW   = 4'd2;
    localparam logic [3:0] OP_CW    = 4'd3;
    localparam logic [3:0] OP_FLIP  = 4'd4;
    localparam logic [3:0] OP_UP    = 4'd5;
    localparam logic [3:0] OP_LEFT  = 4'd6;
    localparam logic [3:0] OP_DOWN  = 4'd7;
    localparam logic [3:0] OP_RIGHT = 4'd8;

    typedef logic signed [DW-1:0] pix_t;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_OUT} state_e;

    localparam pix_t PIX_MIN = pix_t'({1'b1, {(DW-1){1'b0}}});
    localparam pix_t PIX_MAX = pix_t'({1'b0, {(DW-1){1'b1}}});

    function automatic pix_t sat_neg(input pix_t x);
        return (x == PIX_MIN) ? PIX_MAX : -x;
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] r_q, r_d, c_q, c_d;
    pix_t          img_q [NPIX];
    pix_t          img_d [NPIX];
    logic [3:0]    op_q  [NPIX];
    logic [3:0]    op_d  [NPIX];

    // Window corners; r,c never exceed IMG-2 so the +1 cannot wrap.
    logic [LW-1:0] r_p1, c_p1;
    logic [CW-1:0] idx_a, idx_b, idx_c, idx_d;
    pix_t          pa, pb, pc, pd;

    assign r_p1  = r_q + LW'(1);
    assign c_p1  = c_q + LW'(1);
    assign idx_a = {r_q, c_q};
    assign idx_b = {r_q, c_p1};
    assign idx_c = {r_p1, c_q};
    assign idx_d = {r_p1, c_p1};
    assign pa    = img_q[idx_a];
    assign pb    = img_q[idx_b];
    assign pc    = img_q[idx_c];
    assign pd    = img_q[idx_d];

    pix_t                 max_ab, min_ab, max_cd, min_cd, mid_hi, mid_lo, mid_res, avg_res;
    logic signed [DW:0]   mid_sum, mid_adj;
    logic signed [DW+1:0] avg_sum, avg_adj;

    always_comb begin
        max_ab  = (pa > pb) ? pa : pb;
        min_ab  = (pa > pb) ? pb : pa;
        max_cd  = (pc > pd) ? pc : pd;
        min_cd  = (pc > pd) ? pd : pc;
        mid_hi  = (max_ab < max_cd) ? max_ab : max_cd;
        mid_lo  = (min_ab > min_cd) ? min_ab : min_cd;
        // Bias negative sums by divisor-1 so the arithmetic shift truncates toward zero.
        mid_sum = (DW + 1)'(mid_hi) + (DW + 1)'(mid_lo);
        mid_adj = mid_sum + {{DW{1'b0}}, mid_sum[DW]};
        mid_res = pix_t'(mid_adj >>> 1);
        avg_sum = (DW + 2)'(pa) + (DW + 2)'(pb) + (DW + 2)'(pc) + (DW + 2)'(pd);
        avg_adj = avg_sum + {{DW{1'b0}}, avg_sum[DW+1], avg_sum[DW+1]};
        avg_res = pix_t'(avg_adj >>> 2);
    end

    logic [HW-1:0] out_i, out_j;
    logic          zoom;
    logic [LW-1:0] out_row, out_col;

    assign out_i   = cnt_q[2*HW-1:HW];
    assign out_j   = cnt_q[HW-1:0];
    assign zoom    = !r_q[LW-1] && !c_q[LW-1];
    assign out_row = zoom ? r_p1 + LW'(out_i) : {out_i, 1'b0};
    assign out_col = zoom ? c_p1 + LW'(out_j) : {out_j, 1'b0};

    assign busy      = (state_q == S_EXEC) || (state_q == S_OUT);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_valid ? img_q[{out_row, out_col}] : '0;

    always_comb begin
        // NOTE: blocking assignments with every target defaulted first, so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        c_d     = c_q;
        img_d   = img_q;
        op_d    = op_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    img_d[0] = in_data;
                    op_d[0]  = op;
                    cnt_d    = CW'(1);
                    r_d      = WIN_START;
                    c_d      = WIN_START;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    img_d[cnt_q] = in_data;
                    if ({1'b0, cnt_q} < NOPS_W) op_d[cnt_q] = op;
                    if (cnt_q == LAST_PIX) begin
                        cnt_d   = '0;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_EXEC: begin
                case (op_q[cnt_q])
                    OP_MID: begin
                        img_d[idx_a] = mid_res;
                        img_d[idx_b] = mid_res;
                        img_d[idx_c] = mid_res;
                        img_d[idx_d] = mid_res;
                    end
                    OP_AVG: begin
                        img_d[idx_a] = avg_res;
                        img_d[idx_b] = avg_res;
                        img_d[idx_c] = avg_res;
                        img_d[idx_d] = avg_res;
                    end
                    OP_CCW: begin
                        img_d[idx_a] = pb;
                        img_d[idx_b] = pd;
                        img_d[idx_c] = pa;
                        img_d[idx_d] = pc;
                    end
                    OP_CW: begin
                        img_d[idx_a] = pc;
                        img_d[idx_b] = pa;
                        img_d[idx_c] = pd;
                        img_d[idx_d] = pb;
                    end
                    OP_FLIP: begin
                        img_d[idx_a] = sat_neg(pa);
                        img_d[idx_b] = sat_neg(pb);
                        img_d[idx_c] = sat_neg(pc);
                        img_d[idx_d] = sat_neg(pd);
                    end
                    OP_UP:    if (r_q != '0)     r_d = r_q - LW'(1);
                    OP_LEFT:  if (c_q != '0)     c_d = c_q - LW'(1);
                    OP_DOWN:  if (r_q != WIN_MAX) r_d = r_p1;
                    OP_RIGHT: if (c_q != WIN_MAX) c_d = c_p1;
                    default: ;
                endcase
                if (cnt_q == LAST_OP) begin
                    cnt_d   = '0;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OUT: begin
                if (cnt_q == LAST_OUT) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            // NOTE: the image and op arrays are flops, cleared with the rest so an aborted frame leaves nothing behind.
            img_q   <= '{default: '0};
            op_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            c_q     <= c_d;
            img_q   <= img_d;
            op_q    <= op_d;
        end
    end
endmodule
